// File: rtl/simd_alu_pkg.sv
// Shared encodings and lane-grouping helper for the packed SIMD add/sub datapath.
package simd_alu_pkg;

  typedef enum logic [1:0] {
    SAT_WRAP     = 2'b00,
    SAT_SIGNED   = 2'b01,
    SAT_UNSIGNED = 2'b10,
    SAT_RSVD     = 2'b11
  } sat_mode_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Per-lane group membership for a group of 2^grp lanes: {is top lane, is lowest lane}.
  function automatic logic [1:0] grp_mask(input int unsigned grp, input int unsigned lane);
    int unsigned gm1;
    gm1 = (32'd1 << grp) - 32'd1;
    return {((lane & gm1) == gm1), ((lane & gm1) == 32'd0)};
  endfunction

endpackage

// File: rtl/simd_lane_add.sv
// One base-lane adder slice with carry in/out and MSB taps for overflow detection.
module simd_lane_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         msb_a,
  output logic         msb_b,
  output logic         msb_s
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign msb_a = a[W-1];
  assign msb_b = b[W-1];
  assign msb_s = sum[W-1];

endmodule

// File: rtl/simd_sat_alu_pipe.sv
// Two-stage SIMD add/sub with runtime lane grouping, signed/unsigned saturation and sticky status.
module simd_sat_alu_pipe
  import simd_alu_pkg::*;
#(
  parameter int  LANE_W = 8,
  parameter int  LANES  = 4,
  localparam int GW     = $clog2(LANES) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] a,
  input  logic [LANES*LANE_W-1:0] b,
  input  logic                    op,
  input  logic [GW-1:0]           grp,
  input  logic [1:0]              sat_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] c,
  output logic [LANES-1:0]        sat_flags,
  output logic                    sticky_sat,
  input  logic                    sticky_clr
);

  localparam int              STAGES = 2;
  localparam logic [GW-1:0]   GMAX   = GW'($clog2(LANES));
  localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};

  logic [STAGES:1] vld_pipe;
  logic            s1_ld, s2_ld;

  assign s2_ld     = !vld_pipe[2] || out_ready;
  assign s1_ld     = !vld_pipe[1] || s2_ld;
  assign in_ready  = s1_ld;
  assign out_valid = vld_pipe[2];

  logic [LANES-1:0][LANE_W-1:0] a_v, b_v, b_eff, sum_v;
  logic [LANES-1:0]             lo_m, hi_m, msb_a, msb_b, msb_s;
  logic                         lane_cin  [LANES];
  logic                         lane_cout [LANES];
  logic [GW-1:0]                grp_eff;

  assign a_v     = a;
  assign b_v     = b;
  assign grp_eff = (grp > GMAX) ? GMAX : grp;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign {hi_m[i], lo_m[i]} = grp_mask(32'(grp_eff), i);
    assign b_eff[i] = op ? ~b_v[i] : b_v[i];
    // Carry crosses a lane boundary only inside a group; group bases take op as carry-in.
    if (i == 0) begin : g_c0
      assign lane_cin[i] = lo_m[i] ? op : 1'b0;
    end else begin : g_cn
      assign lane_cin[i] = lo_m[i] ? op : lane_cout[i-1];
    end
    simd_lane_add #(.W(LANE_W)) u_add (
      .a     (a_v[i]),
      .b     (b_eff[i]),
      .cin   (lane_cin[i]),
      .sum   (sum_v[i]),
      .cout  (lane_cout[i]),
      .msb_a (msb_a[i]),
      .msb_b (msb_b[i]),
      .msb_s (msb_s[i])
    );
  end

  logic [LANES-1:0][LANE_W-1:0] s1_sum, c_q, nxt_c;
  logic [LANES-1:0]             s1_hi, s1_msb_a, s1_msb_b, s1_msb_s, s1_cout;
  logic [LANES-1:0]             flags_q, nxt_f;
  logic                         s1_op, sticky_q, g_ovf, g_neg;
  sat_mode_e                    s1_mode;

  // Walk lanes top-down so each lane inherits the verdict of its group's top lane.
  always_comb begin
    nxt_c = '0;
    nxt_f = '0;
    g_ovf = 1'b0;
    g_neg = 1'b0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (s1_hi[i]) begin
        g_neg = s1_msb_a[i];
        case (s1_mode)
          SAT_SIGNED:   g_ovf = (s1_msb_a[i] == s1_msb_b[i]) && (s1_msb_s[i] != s1_msb_a[i]);
          SAT_UNSIGNED: g_ovf = s1_op ? !s1_cout[i] : s1_cout[i];
          default:      g_ovf = 1'b0;
        endcase
      end
      nxt_f[i] = g_ovf;
      if (!g_ovf)                      nxt_c[i] = s1_sum[i];
      else if (s1_mode == SAT_UNSIGNED) nxt_c[i] = s1_op ? '0 : '1;
      else if (s1_hi[i])               nxt_c[i] = g_neg ? SMIN : SMAX;
      else                             nxt_c[i] = g_neg ? '0 : '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_sum   <= '0;
      s1_hi    <= '0;
      s1_msb_a <= '0;
      s1_msb_b <= '0;
      s1_msb_s <= '0;
      s1_cout  <= '0;
      s1_op    <= 1'b0;
      s1_mode  <= SAT_WRAP;
      c_q      <= '0;
      flags_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (s1_ld) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          s1_sum   <= sum_v;
          s1_hi    <= hi_m;
          s1_msb_a <= msb_a;
          s1_msb_b <= msb_b;
          s1_msb_s <= msb_s;
          for (int i = 0; i < LANES; i++) s1_cout[i] <= lane_cout[i];
          s1_op    <= op;
          s1_mode  <= sat_mode_e'(sat_mode);
        end
      end
      if (s2_ld) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          c_q     <= nxt_c;
          flags_q <= nxt_f;
        end
      end
      // A saturating transfer in the same cycle as a clear keeps the flag set.
      sticky_q <= (vld_pipe[2] && out_ready && |flags_q) || (sticky_q && !sticky_clr);
    end
  end

  assign c          = c_q;
  assign sat_flags  = flags_q;
  assign sticky_sat = sticky_q;

endmodule

// File: tb/tb_simd_sat_alu_pipe.sv
// Scoreboard bench for simd_sat_alu_pipe: group-wide integer model, stall, latency and reset checks.
module tb_simd_sat_alu_pipe;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int DW     = LANE_W * LANES;
  localparam int GW     = $clog2(LANES) + 1;
  localparam int LOG2   = $clog2(LANES);

  logic            clk = 1'b0, rst = 1'b0;
  logic            in_valid = 1'b0, in_ready, op = 1'b0;
  logic            out_valid, out_ready = 1'b1, sticky_sat, sticky_clr = 1'b0;
  logic [DW-1:0]   a = '0, b = '0, c;
  logic [GW-1:0]   grp = '0;
  logic [1:0]      sat_mode = '0;
  logic [LANES-1:0] sat_flags;

  simd_sat_alu_pipe #(.LANE_W(LANE_W), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .grp(grp), .sat_mode(sat_mode),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .sat_flags(sat_flags),
    .sticky_sat(sticky_sat), .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0]    c;
    logic [LANES-1:0] f;
    int               acc;
  } exp_t;

  exp_t             q[$];
  bit               lit = 0, chk_lat = 0, exp_sticky = 0, hold_prev = 0, done = 0;
  logic [DW-1:0]    lit_c = '0, prev_c = '0;
  logic [LANES-1:0] lit_f = '0, prev_f = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Each group evaluated as one wide integer, then clamped to its range.
  function automatic void model(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                input logic opv, input int gv, input logic [1:0] md,
                                output logic [DW-1:0] cv, output logic [LANES-1:0] fv);
    int g, gl, gb;
    longint ua, ub, sa, sb, r, msk, half;
    bit sat;
    cv = '0;
    fv = '0;
    g    = (gv > LOG2) ? LOG2 : gv;
    gl   = 1 << g;
    gb   = gl * LANE_W;
    msk  = (longint'(1) << gb) - 1;
    half = longint'(1) << (gb - 1);
    for (int k = 0; k < LANES / gl; k++) begin
      ua  = longint'(av >> (k * gb)) & msk;
      ub  = longint'(bv >> (k * gb)) & msk;
      sat = 0;
      if (md == 2'b01) begin
        sa = (ua >= half) ? ua - (msk + 1) : ua;
        sb = (ub >= half) ? ub - (msk + 1) : ub;
        r  = opv ? sa - sb : sa + sb;
        if (r > half - 1) begin r = half - 1; sat = 1; end
        else if (r < -half) begin r = -half; sat = 1; end
      end else begin
        r = opv ? ua - ub : ua + ub;
        if (md == 2'b10) begin
          if (r < 0) begin r = 0; sat = 1; end
          else if (r > msk) begin r = msk; sat = 1; end
        end
      end
      r = r & msk;
      for (int l = 0; l < gl; l++) fv[k*gl + l] = sat;
      cv = cv | (DW'(r) << (k * gb));
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   xs;
    if (rst) begin
      q.delete();
      exp_sticky = 0;
      hold_prev  = 0;
    end else begin
      chk("sticky", 64'(sticky_sat), 64'(exp_sticky));
      if (hold_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_c", 64'(c), 64'(prev_c));
        chk("hold_flags", 64'(sat_flags), 64'(prev_f));
      end
      xs = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("stale_out", 64'(out_valid), 64'd0);
        else begin
          e = q.pop_front();
          chk("c", 64'(c), 64'(e.c));
          chk("flags", 64'(sat_flags), 64'(e.f));
          if (chk_lat) chk("latency", 64'(cyc - e.acc), 64'd2);
          xs = (e.f != '0);
        end
      end
      exp_sticky = xs || (exp_sticky && !sticky_clr);
      hold_prev  = out_valid && !out_ready;
      prev_c     = c;
      prev_f     = sat_flags;
      if (in_valid && in_ready) begin
        if (lit) begin e.c = lit_c; e.f = lit_f; end
        else model(a, b, op, int'(grp), sat_mode, e.c, e.f);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic opv,
                       input logic [GW-1:0] gv, input logic [1:0] md);
    a = av; b = bv; op = opv; grp = gv; sat_mode = md; in_valid = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic opv,
                      input logic [GW-1:0] gv, input logic [1:0] md,
                      input bit use_lit, input logic [DW-1:0] lc, input logic [LANES-1:0] lf);
    bit ok = 0;
    lit = use_lit; lit_c = lc; lit_f = lf;
    drive(av, bv, opv, gv, md);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lit = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_c", 64'(c), 64'd0);
    chk("rst_flags", 64'(sat_flags), 64'd0);
    chk("rst_sticky", 64'(sticky_sat), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed vectors with hand-derived results
    send(32'h7F01_8010, 32'h0101_FFF0, 1'b0, 3'd0, 2'b01, 1, 32'h7F02_8000, 4'b1010);
    drain();
    @(negedge clk);
    chk("sticky_after_sat", 64'(sticky_sat), 64'd1);
    @(posedge clk); #1;
    send(32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 3'd2, 2'b10, 1, 32'hFFFF_FFFF, 4'b1111);
    send(32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 3'd2, 2'b00, 1, 32'h0000_0010, 4'b0000);
    send(32'h0005_1000, 32'h0006_0001, 1'b1, 3'd1, 2'b10, 1, 32'h0000_0FFF, 4'b1100);
    send(32'h7F00_0000, 32'h0100_0000, 1'b0, 3'd7, 2'b01, 1, 32'h7FFF_FFFF, 4'b1111);
    send(32'h7F7F_7F7F, 32'h0101_0101, 1'b0, 3'd0, 2'b11, 1, 32'h8080_8080, 4'b0000);
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 3'd2, 2'b01, 1, 32'h8000_0000, 4'b1111);
    drain();

    // Backpressure: two beats fill the pipe, third waits
    out_ready = 1'b0;
    drive(32'h0102_0304, 32'h1010_1010, 1'b0, 3'd0, 2'b00);
    @(negedge clk); chk("bp_rdy0", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive(32'h7F7F_7F7F, 32'h0101_0101, 1'b0, 3'd1, 2'b01);
    @(negedge clk); chk("bp_rdy1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive(32'h0000_0001, 32'h0000_0002, 1'b1, 3'd0, 2'b10);
    @(negedge clk); chk("bp_rdy2", 64'(in_ready), 64'd0);
    repeat (3) begin
      @(negedge clk); chk("bp_stall_rdy", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out0", 64'(out_valid), 64'd1);
    chk("bp_rdy_rel", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("bp_out1", 64'(out_valid), 64'd1);
    @(negedge clk); chk("bp_out2", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    chk("bp_drain", 64'(q.size()), 64'd0);

    // Clear with no transfer in flight
    sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    @(negedge clk); chk("sticky_clr", 64'(sticky_sat), 64'd0);
    @(posedge clk); #1;

    // Back-to-back stream; clear lands on a saturating transfer
    chk_lat = 1;
    for (int i = 0; i < 8; i++) begin
      sticky_clr = (i == 5);
      send(32'h7F7F_7F7F, 32'h0101_0101, 1'b0, GW'(i % 3), 2'b01, 0, '0, '0);
    end
    sticky_clr = 1'b0;
    drain();
    chk_lat = 0;

    // Mixed random beats under random backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 16; i++)
          send(DW'($urandom()), DW'($urandom()), 1'($urandom_range(0, 1)),
               GW'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 0, '0, '0);
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with both stages occupied
    send(32'h7F00_0000, 32'h0100_0000, 1'b0, 3'd2, 2'b01, 0, '0, '0);
    drain();
    out_ready = 1'b0;
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 3'd0, 2'b00, 0, '0, '0);
    send(32'h3333_3333, 32'h4444_4444, 1'b0, 3'd0, 2'b00, 0, '0, '0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_sticky", 64'(sticky_sat), 64'd0);
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk); chk("rst_rel_ready", 64'(in_ready), 64'd1);
    repeat (4) begin
      @(negedge clk); chk("rst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_sat_alu_pipe.md
Name: simd_sat_alu_pipe

Overview:
- Pipelined, parametrised SIMD add/subtract unit with selectable lane grouping and saturation modes.
- Generalises the 4x8-bit packed saturating adder to N lanes of W bits.
- Adds subtraction, signed and unsigned saturation, per-lane saturation flags, a sticky status register, and a valid/ready handshake.
- Sits between the operand register read stage and writeback in the packed-math datapath.

Parameters:
- LANE_W, 8, bits per base lane (>=2).
- LANES, 4, number of base lanes; power of two, >=1.
- GW, $clog2(LANES)+1 (derived localparam, not overridable), width of the grp input.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  LANES*LANE_W  operand A, packed, lane 0 at LSBs.
- b  in  LANES*LANE_W  operand B.
- op  in  1  0 = A+B, 1 = A-B.
- grp  in  GW  group size = 2^grp base lanes; values > log2(LANES) are treated as log2(LANES).
- sat_mode  in  2  00 = wrap, 01 = signed saturate, 10 = unsigned saturate, 11 = wrap (reserved).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- c  out  LANES*LANE_W  result.
- sat_flags  out  LANES  per-lane saturation occurred; a group's flag is replicated on all of its lanes.
- sticky_sat  out  1  OR of all sat_flags delivered since the last clear.
- sticky_clr  in  1  synchronous clear of sticky_sat.

Behaviour:
- Reset (async assert, sync release): out_valid=0, c=0, sat_flags=0, sticky_sat=0, and both stage-valid bits 0. in_ready=1 once reset is released.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is transferred when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, c, sat_flags and out_valid are held stable.
- Pipeline, two register stages (S1, S2):
  - Latency is exactly 2 cycles from acceptance to out_valid when not stalled; throughput is 1 beat per cycle.
  - S1 computes carry-chained lane sums. For subtraction, B is inverted and carry-in of the group's lowest lane is 1. Carry between lanes propagates only inside a group; each group's lowest lane takes carry-in = op.
  - S1 registers the sums plus, per group, the top-lane MSBs of A, B' (B or ~B as used in the sum) and the sum, the final carry, op, grp and sat_mode.
  - S2 applies saturation and registers c and sat_flags.
- Ready rule:
  - S2 can load when S2 is empty or out_ready=1.
  - S1 can load when S1 is empty or S2 can load.
  - in_ready = S1 can load. in_ready must not combinationally depend on in_valid.
- Overflow detection, per group:
  - Signed: MSB(A)==MSB(B') && MSB(sum)!=MSB(A).
  - Unsigned add: carry_out=1.
  - Unsigned sub: carry_out=0 (borrow).
- Saturation values, per group:
  - Signed overflow: MSB(A)=0 gives max positive (0 followed by all 1s); MSB(A)=1 gives min negative (1 followed by all 0s).
  - Unsigned: add overflow gives all 1s; sub borrow gives all 0s.
  - The saturated value spans the whole group: only the group's top lane carries the sign bit, all other lanes are all 1s or all 0s.
  - Wrap mode never saturates and sat_flags=0.
- Sticky status:
  - sticky_sat sets on a transferred beat that has any sat_flag set.
  - sticky_clr clears it. If clear and set occur in the same cycle, set wins.
- Mixed groupings: consecutive beats with different grp/op/sat_mode are fully independent; no state is carried between beats.
- Reset mid-operation: in-flight beats are discarded with no output and no sticky update.

Decomposition:
- Shared package simd_alu_pkg:
  - sat_mode encodings SAT_WRAP, SAT_SIGNED, SAT_UNSIGNED;
  - op encodings OP_ADD, OP_SUB;
  - function grp_mask(grp) returning the per-lane "lowest lane of group" and "top lane of group" masks.
- One natural sub-module, simd_lane_add: one LANE_W adder slice with carry-in/carry-out and MSB taps. It is instantiated LANES times under generate.
- Saturation select stays inline in S2.

Test Plan (LANE_W=8, LANES=4):
- Signed saturating add, grp=0, sat_mode=01, op=0, a=0x7F01_8010, b=0x0101_FFF0 -> c=0x7F02_8000, sat_flags=1010, sticky_sat=1 after transfer.
- Unsigned saturating add, grp=2, a=0xFFFFFFF0, b=0x00000020 -> c=0xFFFFFFFF, sat_flags=1111; the same beat in wrap mode -> c=0x00000010, sat_flags=0000.
- Unsigned saturating sub, grp=1, op=1, a=0x0005_1000, b=0x0006_0001 -> c=0x0000_0FFF, sat_flags=1100.
- Backpressure:
  - Stimulus: hold out_ready=0 and present 3 back-to-back beats.
  - First 2 beats are accepted; in_ready=0 on the 3rd cycle.
  - c stays stable for the whole stall.
  - Release out_ready: all 3 results emerge in order, one per cycle.
- Latency and throughput: with out_ready=1, stream 8 beats and check out_valid rises exactly 2 cycles after the first accept with no bubbles. Then pulse sticky_clr in the same cycle as a saturating transfer -> sticky_sat=1 (set wins).
- Reset mid-op: with S1 and S2 both full, assert rst asynchronously between edges -> out_valid=0 and sticky_sat=0 immediately. After release, in_ready=1 and no stale beat appears.
